wxzip_feed: RTL and testbench

Upstream packing stage for the `wxzip` core. It accepts a framed byte stream and packs it into 34-bit `wxzip` input words, with frame-end and byte-count encoding. It drives `din`/`wr_en` directly and throttles the byte source from `half_full`. It also traps the core's `error` output into a sticky flag and drains input afterwards, so upstream never deadlocks.

---
 rtl/wxzip_feed.sv | 109 ++++++++++
 tb/tb_wxzip_feed.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wxzip_feed.sv
// Packs a framed byte stream into 34-bit wxzip words (kind + data); wr_en/din registered, 1 cycle after the completing byte.
// Backpressure: in_ready drops combinationally on half_full; once the core reports error, input is drained and discarded.
// Optional statistics counters (frame_cnt, byte_cnt) are built when WXZIP_FEED_STATS_EN is defined.
module wxzip_feed #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [33:0]       din,
    output logic              wr_en,
    input  logic              half_full,
    input  logic              error,
    output logic              busy,
    output logic              err_sticky
`ifdef WXZIP_FEED_STATS_EN
    ,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] byte_cnt
`endif
);

    typedef enum logic [1:0] {
        KIND_FULL  = 2'b00,
        KIND_LAST  = 2'b01,
        KIND_SHORT = 2'b10
    } kind_e;

    logic [23:0] byte_buf;
    logic [1:0]  idx;
    logic        accept;
    logic        keep;
    logic        complete;
    logic [23:0] lanes;
    logic [33:0] word;

    assign in_ready = !rst && (err_sticky || !half_full);
    assign accept   = in_valid && in_ready;
    assign keep     = accept && !err_sticky;
    assign complete = (idx == 2'd3) || in_last;
    assign busy     = (idx != 2'd0);

    // Current byte merged into its lane; lanes above idx are still zero.
    always_comb begin
        lanes = byte_buf;
        case (idx)
            2'd0:    lanes[7:0]   = in_data;
            2'd1:    lanes[15:8]  = in_data;
            2'd2:    lanes[23:16] = in_data;
            default: lanes = byte_buf;
        endcase
    end

    always_comb begin
        word = '0;
        if (idx == 2'd3) begin
            word = {(in_last ? KIND_LAST : KIND_FULL), in_data, byte_buf};
        end else begin
            word = {KIND_SHORT, 6'd0, idx + 2'd1, lanes};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_buf   <= '0;
            idx        <= '0;
            din        <= '0;
            wr_en      <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (error) begin
                err_sticky <= 1'b1;
            end
            if (accept && err_sticky) begin
                byte_buf <= '0;
                idx      <= '0;
            end else if (keep) begin
                if (complete) begin
                    din      <= word;
                    wr_en    <= 1'b1;
                    byte_buf <= '0;
                    idx      <= '0;
                end else begin
                    byte_buf <= lanes;
                    idx      <= idx + 2'd1;
                end
            end
        end
    end

`ifdef WXZIP_FEED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
        end else if (keep) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (complete && ((idx != 2'd3) || in_last)) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wxzip_feed.sv
// Directed vector bench for wxzip_feed: one table row per clock cycle, plus a hand sequence for error drain and recovery.
module tb_wxzip_feed;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [33:0] din;
    logic        wr_en;
    logic        half_full;
    logic        error;
    logic        busy;
    logic        err_sticky;
`ifdef WXZIP_FEED_STATS_EN
    logic [31:0] frame_cnt;
    logic [31:0] byte_cnt;
`endif

    always #5 clk = ~clk;

    wxzip_feed #(.STAT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .din       (din),
        .wr_en     (wr_en),
        .half_full (half_full),
        .error     (error),
        .busy      (busy),
        .err_sticky(err_sticky)
`ifdef WXZIP_FEED_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .byte_cnt  (byte_cnt)
`endif
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        hf;
        logic        er;
        logic        x_rdy;
        logic        x_wr;
        logic [33:0] x_din;
        logic        x_busy;
        logic        x_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic l,
                       input logic hf, input logic er, input logic x_rdy, input logic x_wr,
                       input logic [33:0] x_din, input logic x_busy, input logic x_err);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.l = l; t.hf = hf; t.er = er;
        t.x_rdy = x_rdy; t.x_wr = x_wr; t.x_din = x_din; t.x_busy = x_busy; t.x_err = x_err;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int step, input logic [33:0] act, input logic [33:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic l,
                         input logic hf, input logic er);
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_last = l; half_full = hf; error = er;
    endtask

    initial begin
        int wr_seen;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; half_full = 1'b0; error = 1'b0;

        //   r  v  d      l  hf er   rdy wr din              busy err
        add(1, 0, 8'h00, 0, 0, 0,   0,  0, 34'h0,            0,   0);
        add(1, 1, 8'h55, 0, 0, 0,   0,  0, 34'h0,            0,   0);
        add(0, 1, 8'h11, 0, 0, 0,   1,  0, 34'h0,            1,   0);
        add(0, 1, 8'h22, 0, 0, 0,   1,  0, 34'h0,            1,   0);
        add(0, 1, 8'h33, 0, 0, 0,   1,  0, 34'h0,            1,   0);
        add(0, 1, 8'h44, 1, 0, 0,   1,  1, 34'h1_4433_2211,  0,   0);
        add(0, 0, 8'h00, 0, 0, 0,   1,  0, 34'h1_4433_2211,  0,   0);
        add(0, 1, 8'h01, 0, 0, 0,   1,  0, 34'h1_4433_2211,  1,   0);
        add(0, 1, 8'h02, 0, 0, 0,   1,  0, 34'h1_4433_2211,  1,   0);
        add(0, 1, 8'h03, 0, 0, 0,   1,  0, 34'h1_4433_2211,  1,   0);
        add(0, 1, 8'h04, 0, 0, 0,   1,  1, 34'h0_0403_0201,  0,   0);
        add(0, 1, 8'h05, 0, 0, 0,   1,  0, 34'h0_0403_0201,  1,   0);
        add(0, 1, 8'h06, 1, 0, 0,   1,  1, 34'h2_0200_0605,  0,   0);
        add(0, 1, 8'hAA, 1, 0, 0,   1,  1, 34'h2_0100_00AA,  0,   0);
        add(0, 1, 8'hBB, 1, 0, 0,   1,  1, 34'h2_0100_00BB,  0,   0);
        add(0, 1, 8'hC1, 0, 0, 0,   1,  0, 34'h2_0100_00BB,  1,   0);
        for (int i = 0; i < 10; i++)
            add(0, 1, 8'hC2, 0, 1, 0, 0,  0, 34'h2_0100_00BB,  1,   0);
        add(0, 1, 8'hC2, 0, 0, 0,   1,  0, 34'h2_0100_00BB,  1,   0);
        add(0, 1, 8'hC3, 0, 0, 0,   1,  0, 34'h2_0100_00BB,  1,   0);
        add(0, 1, 8'hC4, 1, 0, 0,   1,  1, 34'h1_C4C3_C2C1,  0,   0);
        add(0, 1, 8'hD1, 0, 0, 0,   1,  0, 34'h1_C4C3_C2C1,  1,   0);
        add(0, 0, 8'hFF, 1, 0, 0,   1,  0, 34'h1_C4C3_C2C1,  1,   0);
        add(0, 1, 8'hD2, 1, 0, 0,   1,  1, 34'h2_0200_D2D1,  0,   0);
        // error coinciding with a completing byte still writes that word
        add(0, 1, 8'hE1, 1, 0, 1,   1,  1, 34'h2_0100_00E1,  0,   1);
        for (int i = 1; i <= 8; i++)
            add(0, 1, 8'(i), (i == 8), 1, 0, 1, 0, 34'h2_0100_00E1, 0, 1);
        add(1, 0, 8'h00, 0, 0, 0,   0,  0, 34'h0,            0,   0);
        add(0, 1, 8'h01, 0, 0, 0,   1,  0, 34'h0,            1,   0);
        add(0, 1, 8'h02, 0, 0, 0,   1,  0, 34'h0,            1,   0);
        add(1, 1, 8'h03, 0, 0, 0,   0,  0, 34'h0,            0,   0);
        add(0, 1, 8'hA1, 1, 0, 0,   1,  1, 34'h2_0100_00A1,  0,   0);
        add(0, 0, 8'h00, 0, 0, 0,   1,  0, 34'h2_0100_00A1,  0,   0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].hf, vecs[i].er);
            #1;
            n_vec++;
            chk("in_ready", i, 34'(in_ready), 34'(vecs[i].x_rdy));
            @(posedge clk);
            #1;
            chk("wr_en", i, 34'(wr_en), 34'(vecs[i].x_wr));
            chk("din", i, din, vecs[i].x_din);
            chk("busy", i, 34'(busy), 34'(vecs[i].x_busy));
            chk("err_sticky", i, 34'(err_sticky), 34'(vecs[i].x_err));
        end

`ifdef WXZIP_FEED_STATS_EN
        n_vec++;
        chk("frame_cnt", 0, 34'(frame_cnt), 34'd1);
        chk("byte_cnt", 0, 34'(byte_cnt), 34'd1);
`endif

        // Standalone error pulse with no traffic, then a full frame must be drained silently.
        drive(0, 0, 8'h00, 0, 0, 1);
        drive(0, 0, 8'h00, 0, 0, 0);
        wr_seen = 0;
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 8'(i), (i == 8), 0, 0);
            #1;
            n_vec++;
            chk("drain_ready", i, 34'(in_ready), 34'd1);
            @(posedge clk);
            #1;
            if (wr_en) wr_seen++;
        end
        n_vec++;
        chk("drain_wr_count", 0, 34'(wr_seen), 34'd0);
        chk("drain_sticky", 0, 34'(err_sticky), 34'd1);
        chk("drain_din_hold", 0, din, 34'h2_0100_00A1);

        // Reset clears the trap and packing resumes from lane 0.
        drive(1, 0, 8'h00, 0, 0, 0);
        @(posedge clk);
        #1;
        n_vec++;
        chk("rst_sticky", 0, 34'(err_sticky), 34'd0);
        wr_seen = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'(8'h5A + i), (i == 3), 0, 0);
            @(posedge clk);
            #1;
            if (wr_en) wr_seen++;
        end
        n_vec++;
        chk("resume_wr_count", 0, 34'(wr_seen), 34'd1);
        chk("resume_din", 0, din, 34'h1_5D5C_5B5A);
        drive(0, 0, 8'h00, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("resume_wr_drop", 0, 34'(wr_en), 34'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
